exec_unit_sequencer: RTL and testbench

// Issue/stall sequencer for the fixed-latency units of the execute stage (MUL32_32, DIV32, fadd, fsub, fmul, finv, fsqrt).

---
 rtl/exec_unit_sequencer_pkg.sv | 18 +
 rtl/exec_unit_sequencer_lat_lookup.sv | 32 +++
 rtl/exec_unit_sequencer.sv | 81 ++++++++
 tb/tb_exec_unit_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_sequencer_pkg.sv
// exec_unit_sequencer_pkg: unit/state enums and opcode encodings shared by the sequencer and its lookup
package exec_unit_sequencer_pkg;
  typedef enum logic [2:0] {UNIT_NONE, UNIT_MUL, UNIT_DIV, UNIT_FADD, UNIT_FMUL, UNIT_FINV, UNIT_FSQRT} unit_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam logic [1:0] OP_IMM  = 2'b00;
  localparam logic [1:0] OP_FUNC = 2'b01;
  localparam logic [1:0] OP_FPU  = 2'b10;
  localparam logic [3:0] FUNC_ADD  = 4'd0;
  localparam logic [3:0] FUNC_SUB  = 4'd1;
  localparam logic [3:0] FUNC_MULT = 4'd2;
  localparam logic [3:0] FUNC_DIV  = 4'd3;
  localparam logic [3:0] FPU_ADD  = 4'd0;
  localparam logic [3:0] FPU_SUB  = 4'd1;
  localparam logic [3:0] FPU_MUL  = 4'd2;
  localparam logic [3:0] FPU_INV  = 4'd3;
  localparam logic [3:0] FPU_SQRT = 4'd4;
  localparam logic [3:0] FPU_NEG  = 4'd5;
endpackage

// File: rtl/exec_unit_sequencer_lat_lookup.sv
// exec_lat_lookup: maps a decoded (op_type, instr) to its execution unit and fixed latency; 0 means single-cycle
module exec_lat_lookup
  import exec_unit_sequencer_pkg::*;
#(
  parameter int LAT_MUL   = 2,
  parameter int LAT_DIV   = 36,
  parameter int LAT_FADD  = 3,
  parameter int LAT_FMUL  = 2,
  parameter int LAT_FINV  = 4,
  parameter int LAT_FSQRT = 4,
  parameter int CNT_W     = 6
) (
  input  logic [1:0]       op_type,
  input  logic [3:0]       instr,
  output unit_e            unit,
  output logic [CNT_W-1:0] lat
);
  always_comb begin
    unit = UNIT_NONE;
    lat  = '0;
    case ({op_type, instr})
      {OP_FUNC, FUNC_MULT}: begin unit = UNIT_MUL;   lat = CNT_W'(LAT_MUL);   end
      {OP_FUNC, FUNC_DIV}:  begin unit = UNIT_DIV;   lat = CNT_W'(LAT_DIV);   end
      {OP_FPU, FPU_ADD},
      {OP_FPU, FPU_SUB}:    begin unit = UNIT_FADD;  lat = CNT_W'(LAT_FADD);  end
      {OP_FPU, FPU_MUL}:    begin unit = UNIT_FMUL;  lat = CNT_W'(LAT_FMUL);  end
      {OP_FPU, FPU_INV}:    begin unit = UNIT_FINV;  lat = CNT_W'(LAT_FINV);  end
      {OP_FPU, FPU_SQRT}:   begin unit = UNIT_FSQRT; lat = CNT_W'(LAT_FSQRT); end
      default: ;
    endcase
  end
endmodule

// File: rtl/exec_unit_sequencer.sv
// exec_unit_sequencer: stalls the pipeline for a multi-cycle op's exact latency, then pulses done
module exec_unit_sequencer
  import exec_unit_sequencer_pkg::*;
#(
  parameter int LAT_MUL   = 2,
  parameter int LAT_DIV   = 36,
  parameter int LAT_FADD  = 3,
  parameter int LAT_FMUL  = 2,
  parameter int LAT_FINV  = 4,
  parameter int LAT_FSQRT = 4,
  parameter int CNT_W     = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        hazard,
  input  logic        flush,
  input  logic [1:0]  op_type,
  input  logic [3:0]  instr,
  input  logic        stat_clr,
  output logic        busy,
  output logic        done,
  output unit_e       unit_sel,
  output logic [31:0] stall_cycles
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat;
  unit_e            unit, unit_sel_q, unit_sel_d;
  logic             done_q, done_d, accept;
  logic [31:0]      stall_q, stall_d;
  exec_lat_lookup #(
    .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .LAT_FADD(LAT_FADD), .LAT_FMUL(LAT_FMUL),
    .LAT_FINV(LAT_FINV), .LAT_FSQRT(LAT_FSQRT), .CNT_W(CNT_W)
  ) u_lookup (
    .op_type(op_type),
    .instr(instr),
    .unit(unit),
    .lat(lat)
  );
  // cnt counts the busy cycles still owed after the current one; the accept cycle itself is the first
  always_comb begin
    accept = rstn & start & ~hazard & ~flush & (lat != '0) & (state_q != BUSY);
    busy = accept | (state_q == BUSY);
    state_d = state_q;
    cnt_d = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (accept) begin
      state_d = (lat == CNT_ONE) ? DONE : BUSY;
      cnt_d = lat - CNT_ONE;
    end else if (state_q == BUSY) begin
      state_d = (cnt_q == CNT_ONE) ? DONE : BUSY;
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      state_d = IDLE;
    end
    done_d = (state_d == DONE);
    unit_sel_d = accept ? unit : unit_sel_q;
    stall_d = stat_clr ? '0 : (busy && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      unit_sel_q <= UNIT_NONE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      unit_sel_q <= unit_sel_d;
      stall_q <= stall_d;
    end
  end
  assign done = done_q;
  assign unit_sel = unit_sel_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_exec_unit_sequencer.sv
// tb_exec_unit_sequencer: directed scenarios plus randomized traffic against a latency-table reference model
module tb_exec_unit_sequencer;
  import exec_unit_sequencer_pkg::*;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, hazard = 1'b0, flush = 1'b0, stat_clr = 1'b0;
  logic [1:0] op_type = 2'b00;
  logic [3:0] instr = 4'd0;
  logic busy, done;
  unit_e unit_sel;
  logic [31:0] stall_cycles;
  int errors = 0, checks = 0;

  exec_unit_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .hazard(hazard), .flush(flush),
    .op_type(op_type), .instr(instr), .stat_clr(stat_clr),
    .busy(busy), .done(done), .unit_sel(unit_sel), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input logic [1:0] ot, input logic [3:0] in);
    if (ot == OP_FUNC && in == FUNC_MULT) return 2;
    if (ot == OP_FUNC && in == FUNC_DIV) return 36;
    if (ot == OP_FPU && (in == FPU_ADD || in == FPU_SUB)) return 3;
    if (ot == OP_FPU && in == FPU_MUL) return 2;
    if (ot == OP_FPU && (in == FPU_INV || in == FPU_SQRT)) return 4;
    return 0;
  endfunction

  function automatic unit_e unit_of(input logic [1:0] ot, input logic [3:0] in);
    if (ot == OP_FUNC && in == FUNC_MULT) return UNIT_MUL;
    if (ot == OP_FUNC && in == FUNC_DIV) return UNIT_DIV;
    if (ot == OP_FPU && (in == FPU_ADD || in == FPU_SUB)) return UNIT_FADD;
    if (ot == OP_FPU && in == FPU_MUL) return UNIT_FMUL;
    if (ot == OP_FPU && in == FPU_INV) return UNIT_FINV;
    if (ot == OP_FPU && in == FPU_SQRT) return UNIT_FSQRT;
    return UNIT_NONE;
  endfunction

  task automatic drive(input bit s, input bit h, input bit f, input logic [1:0] ot, input logic [3:0] in, input bit c);
    @(negedge clk);
    start = s; hazard = h; flush = f; op_type = ot; instr = in; stat_clr = c;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, OP_IMM, 4'd0, 0);
  endtask

  task automatic clear_stats();
    drive(0, 0, 0, OP_IMM, 4'd0, 1);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (unit_sel !== UNIT_NONE) begin errors++; $display("FAIL reset_unit got=%0d exp=%0d", unit_sel, UNIT_NONE); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_mult();
    clear_stats();
    drive(1, 0, 0, OP_FUNC, FUNC_MULT, 0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mult_c0 got busy=%b done=%b exp busy=1 done=0", busy, done); end
    idle();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mult_c1 got busy=%b done=%b exp busy=1 done=0", busy, done); end
    idle();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL mult_c2 got busy=%b done=%b exp busy=0 done=1", busy, done); end
    checks++; if (unit_sel !== UNIT_MUL) begin errors++; $display("FAIL mult_unit got=%0d exp=%0d", unit_sel, UNIT_MUL); end
    checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL mult_stall got=%0d exp=2", stall_cycles); end
    idle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_c3_done got=%b exp=0", done); end
  endtask

  task automatic test_div();
    int nb = 0, nd = 0, done_at = -1;
    clear_stats();
    for (int k = 0; k < 41; k++) begin
      if (k == 0) drive(1, 0, 0, OP_FUNC, FUNC_DIV, 0); else idle();
      nb += int'(busy);
      if (done === 1'b1) begin nd++; if (done_at < 0) done_at = k; end
    end
    checks++; if (nb != 36) begin errors++; $display("FAIL div_busy_cycles got=%0d exp=36", nb); end
    checks++; if (done_at != 36 || nd != 1) begin errors++; $display("FAIL div_done got cycle=%0d pulses=%0d exp cycle=36 pulses=1", done_at, nd); end
    checks++; if (stall_cycles !== 32'd36) begin errors++; $display("FAIL div_stall got=%0d exp=36", stall_cycles); end
    checks++; if (unit_sel !== UNIT_DIV) begin errors++; $display("FAIL div_unit got=%0d exp=%0d", unit_sel, UNIT_DIV); end
  endtask

  task automatic test_single_cycle();
    int nb = 0, nd = 0;
    clear_stats();
    drive(1, 0, 0, OP_FUNC, FUNC_ADD, 0);
    nb += int'(busy);
    drive(1, 0, 0, OP_FPU, FPU_NEG, 0);
    nb += int'(busy);
    drive(1, 0, 0, OP_IMM, 4'd2, 0);
    nb += int'(busy);
    for (int k = 0; k < 5; k++) begin idle(); nb += int'(busy); nd += int'(done); end
    checks++; if (nb != 0) begin errors++; $display("FAIL single_busy got=%0d exp=0", nb); end
    checks++; if (nd != 0) begin errors++; $display("FAIL single_done got=%0d exp=0", nd); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL single_stall got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_hazard();
    int nb = 0, done_at = -1;
    clear_stats();
    drive(1, 1, 0, OP_FPU, FPU_ADD, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hazard_c0 got=%b exp=0", busy); end
    drive(1, 1, 0, OP_FPU, FPU_ADD, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hazard_c1 got=%b exp=0", busy); end
    for (int k = 0; k < 6; k++) begin
      if (k == 0) drive(1, 0, 0, OP_FPU, FPU_ADD, 0); else idle();
      nb += int'(busy);
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    checks++; if (nb != 3) begin errors++; $display("FAIL hazard_busy got=%0d exp=3", nb); end
    checks++; if (done_at != 3) begin errors++; $display("FAIL hazard_done_at got=%0d exp=3", done_at); end
    checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL hazard_stall got=%0d exp=3", stall_cycles); end
  endtask

  task automatic test_flush();
    int nd = 0;
    drive(1, 0, 0, OP_FPU, FPU_INV, 0);
    idle();
    drive(0, 0, 1, OP_IMM, 4'd0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_c2_busy got=%b exp=1", busy); end
    idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_c3_busy got=%b exp=0", busy); end
    nd += int'(done);
    for (int k = 0; k < 6; k++) begin idle(); nd += int'(done); end
    checks++; if (nd != 0) begin errors++; $display("FAIL flush_done got=%0d exp=0", nd); end
    drive(1, 0, 1, OP_FPU, FPU_SQRT, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_with_start got=%b exp=0", busy); end
    idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_with_start_next got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int nb = 0, done_at = -1;
    drive(1, 0, 0, OP_FPU, FPU_MUL, 0);
    idle();
    drive(1, 0, 0, OP_FPU, FPU_SQRT, 0);
    checks++; if (busy !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL b2b_overlap got busy=%b done=%b exp busy=1 done=1", busy, done); end
    checks++; if (unit_sel !== UNIT_FMUL) begin errors++; $display("FAIL b2b_unit_hold got=%0d exp=%0d", unit_sel, UNIT_FMUL); end
    for (int k = 1; k < 8; k++) begin
      idle();
      nb += int'(busy);
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    checks++; if (nb != 3) begin errors++; $display("FAIL b2b_busy_after got=%0d exp=3", nb); end
    checks++; if (done_at != 4) begin errors++; $display("FAIL b2b_done_at got=%0d exp=4", done_at); end
    checks++; if (unit_sel !== UNIT_FSQRT) begin errors++; $display("FAIL b2b_unit got=%0d exp=%0d", unit_sel, UNIT_FSQRT); end
  endtask

  task automatic test_async_reset();
    int nb = 0, nd = 0;
    drive(1, 0, 0, OP_FUNC, FUNC_DIV, 0);
    for (int k = 1; k <= 10; k++) idle();
    rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_outputs got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (unit_sel !== UNIT_NONE || stall_cycles !== 32'd0) begin errors++; $display("FAIL arst_state got unit=%0d stall=%0d exp 0 0", unit_sel, stall_cycles); end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 40; k++) begin idle(); nb += int'(busy); nd += int'(done); end
    checks++; if (nb != 0 || nd != 0) begin errors++; $display("FAIL arst_release got busy=%0d done=%0d exp 0 0", nb, nd); end
  endtask

  task automatic test_stat_clr();
    drive(1, 0, 0, OP_FUNC, FUNC_DIV, 0);
    for (int k = 0; k < 4; k++) idle();
    drive(0, 0, 0, OP_IMM, 4'd0, 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy got=%b exp=1", busy); end
    idle();
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL clr_wins got=%0d exp=0", stall_cycles); end
    idle();
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL clr_resume got=%0d exp=1", stall_cycles); end
    drive(0, 0, 1, OP_IMM, 4'd0, 0);
    idle();
  endtask

  task automatic test_random();
    int rem = 0, lat = 0, bad = 0;
    bit dn = 1'b0, acc, exp_busy;
    unit_e u = UNIT_NONE;
    logic [31:0] st = 32'd0;
    @(negedge clk);
    rstn = 1'b0;
    start = 0; hazard = 0; flush = 0; stat_clr = 0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(2) == 0);
      hazard = ($urandom_range(4) == 0);
      flush = ($urandom_range(19) == 0);
      op_type = 2'($urandom_range(3));
      instr = 4'($urandom_range(7));
      stat_clr = ($urandom_range(29) == 0);
      #1;
      lat = lat_of(op_type, instr);
      acc = start && !hazard && !flush && lat != 0 && rem == 0;
      exp_busy = acc || rem > 0;
      checks++; if (busy !== exp_busy) begin errors++; bad++; if (bad < 10) $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, exp_busy); end
      checks++; if (done !== dn) begin errors++; bad++; if (bad < 10) $display("FAIL rnd_done i=%0d got=%b exp=%b", i, done, dn); end
      checks++; if (unit_sel !== u) begin errors++; bad++; if (bad < 10) $display("FAIL rnd_unit i=%0d got=%0d exp=%0d", i, unit_sel, u); end
      checks++; if (stall_cycles !== st) begin errors++; bad++; if (bad < 10) $display("FAIL rnd_stall i=%0d got=%0d exp=%0d", i, stall_cycles, st); end
      if (flush) begin rem = 0; dn = 1'b0; end
      else if (acc) begin rem = lat - 1; dn = (lat == 1); end
      else if (rem > 0) begin rem--; dn = (rem == 0); end
      else dn = 1'b0;
      if (acc) u = unit_of(op_type, instr);
      st = stat_clr ? 32'd0 : (exp_busy && st != 32'hFFFF_FFFF) ? st + 32'd1 : st;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_single_cycle();
    test_hazard();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_stat_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
